epp_regs_bridge: RTL
====================

Name: epp_regs_bridge

Overview:
- Controller for the EPP slave's core-side register interface. Sequences each EPP address or data access into a single-master internal bus transaction.
- Owns the 8-bit EPP address register, with optional auto-increment after each data access.
- Converts the slave's level REQ into a bus strobe, returns a one-cycle ACK plus read data to the slave, and bounds every bus access with a timeout.
- Sits between the EPP slave and the FPGA-internal register bus.

Parameters:
- AUTO_INC, 1, 1 = increment the address register (mod 256) after every completed data access; 0 = hold it.
- TIMEOUT, 255, bus cycles to wait for BUS_ACK_IN before forcing completion; range 1..255.
- ERR_DATA, 8'hEE, read data returned on a timed-out data read.

Ports:
- CLK  input  1  core clock
- RST_ASYNC  input  1  reset, asynchronous, active-high
- RST_SYNC  input  1  synchronous reset, active-high; same reset values as RST_ASYNC
- EN  input  1  clock enable; when 0 all state and outputs hold
- REGS_WRITE_REQ_IN  input  1  write request level from EPP slave
- REGS_READ_REQ_IN  input  1  read request level from EPP slave
- REGS_ADDR_SEL_IN  input  1  access targets the address register
- REGS_DATA_SEL_IN  input  1  access targets bus data
- REGS_WRITE_DATA_IN  input  8  EPP write data
- REGS_WRITE_ACK_OUT  output  1  one-cycle write-complete pulse
- REGS_READ_ACK_OUT  output  1  one-cycle read-complete pulse
- REGS_READ_DATA_OUT  output  8  read data, valid in the REGS_READ_ACK_OUT cycle
- BUS_ADDR_OUT  output  8  bus address (= address register)
- BUS_WR_OUT  output  1  bus write strobe, held until ack or timeout
- BUS_RD_OUT  output  1  bus read strobe, held until ack or timeout
- BUS_WDATA_OUT  output  8  bus write data
- BUS_RDATA_IN  input  8  bus read data, valid with BUS_ACK_IN
- BUS_ACK_IN  input  1  bus completion, sampled only while a strobe is high
- ERR_OUT  output  1  sticky timeout flag

Behaviour:

Reset values:
- All outputs 0, address register 0x00, state IDLE.

State machine (all transitions gated by EN):
- IDLE
  - On a write or read request with ADDR_SEL:
    - Write: address register <= REGS_WRITE_DATA_IN and ERR_OUT <= 0.
    - Read: REGS_READ_DATA_OUT <= address register.
    - Go to ACK. The ACK pulse appears 2 cycles after the REQ is first seen high.
  - On a write or read request with DATA_SEL:
    - Drive BUS_WR_OUT or BUS_RD_OUT the next cycle.
    - BUS_WDATA_OUT <= REGS_WRITE_DATA_IN.
    - Load the timeout counter with TIMEOUT.
    - Go to BUS.
  - If ADDR_SEL and DATA_SEL are both high, ADDR_SEL wins.
  - If WRITE_REQ and READ_REQ are both high, the request is ignored and the FSM stays in IDLE.
- BUS
  - Strobe held; counter decrements each cycle.
  - On BUS_ACK_IN:
    - Drop the strobe.
    - For a read, capture BUS_RDATA_IN into REGS_READ_DATA_OUT.
    - Go to ACK.
  - If the counter reaches 0 without an ack:
    - Drop the strobe and set ERR_OUT.
    - For a read, REGS_READ_DATA_OUT <= ERR_DATA; a write is dropped.
    - Go to ACK.
  - BUS_ACK_IN in the same cycle the counter hits 0 counts as a normal ack: no error.
- ACK
  - Assert exactly one of REGS_WRITE_ACK_OUT or REGS_READ_ACK_OUT for one cycle, matching the request direction.
  - After a data access with AUTO_INC = 1, increment the address register (0xFF wraps to 0x00).
  - Go to REL.
- REL
  - Wait until both REQ inputs are low, then go to IDLE. This prevents a second ACK to the same request.
  - The EPP slave drops REQ the cycle after ACK.

General rules:
- Strobes are mutually exclusive and never high outside BUS.
- BUS_ACK_IN outside BUS is ignored.
- Reset mid-transaction aborts immediately: strobes low, no ACK, address returns to 0x00.
- REGS_READ_DATA_OUT holds its last value between accesses.

Test Plan:
- Address write 0x40, then address read -> write ACK pulse 1 cycle wide; read ACK with REGS_READ_DATA_OUT = 0x40; BUS_*_OUT never asserted.
- Data write 0xA5 at address 0x40, bus acks after 3 cycles -> BUS_WR_OUT high 3 cycles with BUS_ADDR_OUT = 0x40 and BUS_WDATA_OUT = 0xA5; one write ACK; address becomes 0x41 (AUTO_INC = 1).
- Data read at address 0xFF, BUS_RDATA_IN = 0x3C with immediate ack -> read ACK with data 0x3C; address wraps to 0x00.
- Data read with no BUS_ACK_IN, TIMEOUT = 4 -> BUS_RD_OUT high 4 cycles; read ACK with data 0xEE; ERR_OUT = 1; a following address write clears ERR_OUT to 0.
- REQ held high 5 cycles after ACK -> exactly one ACK pulse; no new bus cycle until REQ has dropped and risen again.
- RST_ASYNC asserted while BUS_WR_OUT is high -> all outputs 0 asynchronously; address 0x00; no ACK after release.

Source files
------------

// File: rtl/epp_regs_bridge_if.sv
// epp_regs_bridge_if: signal bundle between the EPP slave, the register bridge and the
// FPGA-internal register bus.
//
//   REGS_*   request/acknowledge handshake with the EPP slave core side
//   BUS_*    single-master internal register bus
//   ERR_OUT  sticky bus-timeout flag
//
// Modports:
//   slave  - the bridge's view (epp_regs_bridge)
//   master - the environment's view (EPP slave + bus target, or a testbench)
interface epp_regs_bridge_if;

    // EPP slave side
    logic       REGS_WRITE_REQ_IN;
    logic       REGS_READ_REQ_IN;
    logic       REGS_ADDR_SEL_IN;
    logic       REGS_DATA_SEL_IN;
    logic [7:0] REGS_WRITE_DATA_IN;
    logic       REGS_WRITE_ACK_OUT;
    logic       REGS_READ_ACK_OUT;
    logic [7:0] REGS_READ_DATA_OUT;

    // Internal register bus side
    logic [7:0] BUS_ADDR_OUT;
    logic       BUS_WR_OUT;
    logic       BUS_RD_OUT;
    logic [7:0] BUS_WDATA_OUT;
    logic [7:0] BUS_RDATA_IN;
    logic       BUS_ACK_IN;

    logic       ERR_OUT;

    modport slave (
        input  REGS_WRITE_REQ_IN,
        input  REGS_READ_REQ_IN,
        input  REGS_ADDR_SEL_IN,
        input  REGS_DATA_SEL_IN,
        input  REGS_WRITE_DATA_IN,
        output REGS_WRITE_ACK_OUT,
        output REGS_READ_ACK_OUT,
        output REGS_READ_DATA_OUT,
        output BUS_ADDR_OUT,
        output BUS_WR_OUT,
        output BUS_RD_OUT,
        output BUS_WDATA_OUT,
        input  BUS_RDATA_IN,
        input  BUS_ACK_IN,
        output ERR_OUT
    );

    modport master (
        output REGS_WRITE_REQ_IN,
        output REGS_READ_REQ_IN,
        output REGS_ADDR_SEL_IN,
        output REGS_DATA_SEL_IN,
        output REGS_WRITE_DATA_IN,
        input  REGS_WRITE_ACK_OUT,
        input  REGS_READ_ACK_OUT,
        input  REGS_READ_DATA_OUT,
        input  BUS_ADDR_OUT,
        input  BUS_WR_OUT,
        input  BUS_RD_OUT,
        input  BUS_WDATA_OUT,
        output BUS_RDATA_IN,
        output BUS_ACK_IN,
        input  ERR_OUT
    );

endinterface

// File: rtl/epp_regs_bridge.sv
// epp_regs_bridge: sequences EPP slave register accesses onto the internal register bus.
//
// Address accesses read/write the local 8-bit address register. Data accesses become one
// bus transaction at that address; the strobe is held until BUS_ACK_IN or until TIMEOUT
// cycles pass, in which case ERR_OUT is set and reads return ERR_DATA. Each request gets
// exactly one ACK pulse; the bridge then waits for both REQ levels to drop.
//
// Ports:
//   CLK        core clock
//   RST_ASYNC  asynchronous reset, active-high
//   RST_SYNC   synchronous reset, active-high (same reset values)
//   EN         clock enable; when low all state and outputs hold
//   eppIf      EPP handshake + register bus signals (slave modport)
//
// All outputs are registered, so an asynchronous reset clears them immediately.
module epp_regs_bridge #(
    parameter int unsigned AUTO_INC = 1,      // 1: address register increments after data access
    parameter int unsigned TIMEOUT  = 255,    // bus wait limit in cycles, 1..255
    parameter logic [7:0]  ERR_DATA = 8'hEE   // read data on a timed-out bus read
) (
    input  logic               CLK,
    input  logic               RST_ASYNC,
    input  logic               RST_SYNC,
    input  logic               EN,
    epp_regs_bridge_if.slave   eppIf
);

    localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StAck  = 2'd2,
        StRel  = 2'd3
    } state_e;

    state_e     stateQ,    stateD;
    logic [7:0] addrQ,     addrD;
    logic [7:0] cntQ,      cntD;
    logic [7:0] rdataQ,    rdataD;
    logic [7:0] wdataQ,    wdataD;
    logic       busWrQ,    busWrD;
    logic       busRdQ,    busRdD;
    logic       writeAckQ, writeAckD;
    logic       readAckQ,  readAckD;
    logic       errQ,      errD;
    // Direction and target of the access in flight, needed in BUS/ACK.
    logic       isReadQ,   isReadD;
    logic       isDataQ,   isDataD;

    logic wrReq;
    logic rdReq;
    logic oneReq;

    assign wrReq  = eppIf.REGS_WRITE_REQ_IN;
    assign rdReq  = eppIf.REGS_READ_REQ_IN;
    // Simultaneous write and read requests are malformed and ignored.
    assign oneReq = wrReq ^ rdReq;

    // Next-state and output logic
    always_comb begin
        stateD    = stateQ;
        addrD     = addrQ;
        cntD      = cntQ;
        rdataD    = rdataQ;
        wdataD    = wdataQ;
        busWrD    = busWrQ;
        busRdD    = busRdQ;
        writeAckD = 1'b0;
        readAckD  = 1'b0;
        errD      = errQ;
        isReadD   = isReadQ;
        isDataD   = isDataQ;

        if (RST_SYNC) begin
            stateD  = StIdle;
            addrD   = 8'h00;
            cntD    = 8'h00;
            rdataD  = 8'h00;
            wdataD  = 8'h00;
            busWrD  = 1'b0;
            busRdD  = 1'b0;
            errD    = 1'b0;
            isReadD = 1'b0;
            isDataD = 1'b0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (oneReq && eppIf.REGS_ADDR_SEL_IN) begin
                        // Address register access; ADDR_SEL has priority over DATA_SEL.
                        isReadD = rdReq;
                        isDataD = 1'b0;
                        if (wrReq) begin
                            addrD = eppIf.REGS_WRITE_DATA_IN;
                            errD  = 1'b0;
                        end else begin
                            rdataD = addrQ;
                        end
                        stateD = StAck;
                    end else if (oneReq && eppIf.REGS_DATA_SEL_IN) begin
                        isReadD = rdReq;
                        isDataD = 1'b1;
                        busWrD  = wrReq;
                        busRdD  = rdReq;
                        wdataD  = eppIf.REGS_WRITE_DATA_IN;
                        cntD    = TimeoutLoad;
                        stateD  = StBus;
                    end
                end

                StBus: begin
                    cntD = cntQ - 8'd1;
                    // An ack on the final counter cycle wins over the timeout.
                    if (eppIf.BUS_ACK_IN) begin
                        busWrD = 1'b0;
                        busRdD = 1'b0;
                        if (isReadQ) begin
                            rdataD = eppIf.BUS_RDATA_IN;
                        end
                        stateD = StAck;
                    end else if (cntQ <= 8'd1) begin
                        busWrD = 1'b0;
                        busRdD = 1'b0;
                        errD   = 1'b1;
                        if (isReadQ) begin
                            rdataD = ERR_DATA;
                        end
                        stateD = StAck;
                    end
                end

                StAck: begin
                    writeAckD = ~isReadQ;
                    readAckD  = isReadQ;
                    if (isDataQ && (AUTO_INC != 0)) begin
                        addrD = addrQ + 8'd1;
                    end
                    stateD = StRel;
                end

                StRel: begin
                    // Wait for the slave to release REQ so one request yields one ACK.
                    if (!wrReq && !rdReq) begin
                        stateD = StIdle;
                    end
                end

                default: begin
                    stateD = StIdle;
                    busWrD = 1'b0;
                    busRdD = 1'b0;
                end
            endcase
        end
    end

    // State register; RST_SYNC is folded into the next-state values and overrides EN.
    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            stateQ    <= StIdle;
            addrQ     <= 8'h00;
            cntQ      <= 8'h00;
            rdataQ    <= 8'h00;
            wdataQ    <= 8'h00;
            busWrQ    <= 1'b0;
            busRdQ    <= 1'b0;
            writeAckQ <= 1'b0;
            readAckQ  <= 1'b0;
            errQ      <= 1'b0;
            isReadQ   <= 1'b0;
            isDataQ   <= 1'b0;
        end else if (EN || RST_SYNC) begin
            stateQ    <= stateD;
            addrQ     <= addrD;
            cntQ      <= cntD;
            rdataQ    <= rdataD;
            wdataQ    <= wdataD;
            busWrQ    <= busWrD;
            busRdQ    <= busRdD;
            writeAckQ <= writeAckD;
            readAckQ  <= readAckD;
            errQ      <= errD;
            isReadQ   <= isReadD;
            isDataQ   <= isDataD;
        end
    end

    assign eppIf.REGS_WRITE_ACK_OUT = writeAckQ;
    assign eppIf.REGS_READ_ACK_OUT  = readAckQ;
    assign eppIf.REGS_READ_DATA_OUT = rdataQ;
    assign eppIf.BUS_ADDR_OUT       = addrQ;
    assign eppIf.BUS_WR_OUT         = busWrQ;
    assign eppIf.BUS_RD_OUT         = busRdQ;
    assign eppIf.BUS_WDATA_OUT      = wdataQ;
    assign eppIf.ERR_OUT            = errQ;

endmodule
